// File: rtl/dispense_pkg.sv
// Shared defaults and helpers for the dispense item counters.
// Sizing helpers only; no logic, no latency, no flow control.
package dispense_pkg;

  localparam int CNT_W      = 4;
  localparam int TARGET1    = 3;
  localparam int TARGET2    = 3;
  localparam int DEB_CYCLES = 4;

  // Ceiling log2, minimum 1 bit, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sensor_channel.sv
// One sensor channel: 2-flop sync, debounce, rise detect, saturating counter with sticky overflow.
// Clean rise reaches cnt after 2 + DEB_CYCLES + 1 edges; no backpressure, edges while en=0 or clr=1 are dropped.
module sensor_channel #(
  parameter int CNT_W      = dispense_pkg::CNT_W,
  parameter int TARGET     = dispense_pkg::TARGET1,
  parameter int DEB_CYCLES = dispense_pkg::DEB_CYCLES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             clr,
  input  logic             sens,
  output logic [CNT_W-1:0] cnt,
  output logic             at_target,
  output logic             ovf
);

  localparam int               SW        = dispense_pkg::clog2(DEB_CYCLES + 1);
  localparam logic [SW-1:0]    STAB_LAST = SW'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] TGT       = CNT_W'(TARGET);

  logic          s_meta;
  logic          s;
  logic          deb;
  logic          deb_d;
  logic          rise;
  logic [SW-1:0] stab;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
    end else begin
      s_meta <= sens;
      s      <= s_meta;
    end
  end

  // deb only follows s after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      deb   <= 1'b0;
      deb_d <= 1'b0;
      stab  <= '0;
    end else begin
      deb_d <= deb;
      if (s == deb) begin
        stab <= '0;
      end else if (stab == STAB_LAST) begin
        deb  <= s;
        stab <= '0;
      end else begin
        stab <= stab + SW'(1);
      end
    end
  end

  assign rise = deb & ~deb_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (en && rise) begin
      if (cnt == TGT) ovf <= 1'b1;
      else            cnt <= cnt + CNT_W'(1);
    end
  end

  // decode of a flopped count against a constant: glitch-free level
  assign at_target = (cnt == TGT);

endmodule

// File: rtl/dispense_counter.sv
// Two independent sensor channels producing the COUNT1/COUNT2 level flags for the dispenser-check FSM.
// Sensor rise to CNT is 2 + DEB_CYCLES + 1 edges; no backpressure, CLR rearms both channels.
module dispense_counter #(
  parameter int CNT_W      = dispense_pkg::CNT_W,
  parameter int TARGET1    = dispense_pkg::TARGET1,
  parameter int TARGET2    = dispense_pkg::TARGET2,
  parameter int DEB_CYCLES = dispense_pkg::DEB_CYCLES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic             SENS1,
  input  logic             SENS2,
  output logic             COUNT1,
  output logic             COUNT2,
  output logic [CNT_W-1:0] CNT1,
  output logic [CNT_W-1:0] CNT2,
  output logic             OVF1,
  output logic             OVF2
);

  sensor_channel #(
    .CNT_W      (CNT_W),
    .TARGET     (TARGET1),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_ch1 (
    .CLK       (CLK),
    .RST       (RST),
    .en        (EN),
    .clr       (CLR),
    .sens      (SENS1),
    .cnt       (CNT1),
    .at_target (COUNT1),
    .ovf       (OVF1)
  );

  sensor_channel #(
    .CNT_W      (CNT_W),
    .TARGET     (TARGET2),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_ch2 (
    .CLK       (CLK),
    .RST       (RST),
    .en        (EN),
    .clr       (CLR),
    .sens      (SENS2),
    .cnt       (CNT2),
    .at_target (COUNT2),
    .ovf       (OVF2)
  );

endmodule

// File: tb/tb_dispense_counter.sv
// Directed bench for dispense_counter: stimulus queues expected outputs, a monitor compares them.
module tb_dispense_counter;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic       CLR;
  logic       SENS1;
  logic       SENS2;
  logic       COUNT1;
  logic       COUNT2;
  logic [3:0] CNT1;
  logic [3:0] CNT2;
  logic       OVF1;
  logic       OVF2;

  dispense_counter dut (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (EN),
    .CLR    (CLR),
    .SENS1  (SENS1),
    .SENS2  (SENS2),
    .COUNT1 (COUNT1),
    .COUNT2 (COUNT2),
    .CNT1   (CNT1),
    .CNT2   (CNT2),
    .OVF1   (OVF1),
    .OVF2   (OVF2)
  );

  typedef struct packed {
    logic [3:0] cnt1;
    logic [3:0] cnt2;
    logic       c1;
    logic       c2;
    logic       o1;
    logic       o2;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, got, want);
  endtask

  // Monitor: outputs are registered, so sample them mid-cycle on the falling edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, ".CNT1"},   int'(CNT1),   int'(e.cnt1));
        chk({nm, ".CNT2"},   int'(CNT2),   int'(e.cnt2));
        chk({nm, ".COUNT1"}, int'(COUNT1), int'(e.c1));
        chk({nm, ".COUNT2"}, int'(COUNT2), int'(e.c2));
        chk({nm, ".OVF1"},   int'(OVF1),   int'(e.o1));
        chk({nm, ".OVF2"},   int'(OVF2),   int'(e.o2));
      end
    end
  end

  // Inputs change 2 time units after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic exp_push(input string nm, input int c1n, input int c2n,
                          input bit k1, input bit k2, input bit v1, input bit v2);
    exp_t e;
    e.cnt1 = 4'(c1n);
    e.cnt2 = 4'(c2n);
    e.c1   = k1;
    e.c2   = k2;
    e.o1   = v1;
    e.o2   = v2;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL %s.monitor: got %0d pending want 0", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic pulse(input bit a, input bit b);
    SENS1 = a;
    SENS2 = b;
    tick(10);
    SENS1 = 1'b0;
    SENS2 = 1'b0;
    tick(10);
  endtask

  task automatic clear();
    CLR = 1'b1;
    tick(1);
    CLR = 1'b0;
  endtask

  initial begin
    RST = 1'b0; EN = 1'b1; CLR = 1'b0; SENS1 = 1'b1; SENS2 = 1'b1;

    // T1: reset holds everything at zero, then exact 7-edge latency
    tick(5);
    exp_push("t1_reset", 0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    tick(6);
    exp_push("t1_edge6", 0, 0, 0, 0, 0, 0);
    tick(1);
    exp_push("t1_edge7", 1, 1, 0, 0, 0, 0);
    SENS1 = 1'b0; SENS2 = 1'b0;
    tick(10);
    clear();
    exp_push("t1_clr", 0, 0, 0, 0, 0, 0);

    // T2: match
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1);
    exp_push("t2_match", 3, 3, 1, 1, 0, 0);
    clear();
    exp_push("t2_clr", 0, 0, 0, 0, 0, 0);

    // T3: mismatch, then overflow on each channel
    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    exp_push("t3_mismatch", 3, 2, 1, 0, 0, 0);
    pulse(1'b1, 1'b0);
    exp_push("t3_ovf1", 3, 2, 1, 0, 1, 0);
    pulse(1'b0, 1'b1);
    exp_push("t3_match_ovf1", 3, 3, 1, 1, 1, 0);
    pulse(1'b0, 1'b1);
    exp_push("t3_ovf2", 3, 3, 1, 1, 1, 1);
    clear();
    exp_push("t3_clr", 0, 0, 0, 0, 0, 0);

    // T4: bounce and glitch widths
    for (int i = 0; i < 20; i++) begin
      SENS1 = ~SENS1;
      tick(1);
    end
    SENS1 = 1'b0;
    tick(10);
    exp_push("t4_bounce", 0, 0, 0, 0, 0, 0);
    SENS1 = 1'b1; tick(3); SENS1 = 1'b0; tick(10);
    exp_push("t4_glitch3", 0, 0, 0, 0, 0, 0);
    SENS1 = 1'b1; tick(4); SENS1 = 1'b0; tick(10);
    exp_push("t4_glitch4", 1, 0, 0, 0, 0, 0);

    // T5: CLR on the exact rise cycle wins, then COUNT1 drop timing
    pulse(1'b1, 1'b0);
    SENS1 = 1'b1;
    tick(6);
    exp_push("t5_pre", 2, 0, 0, 0, 0, 0);
    CLR = 1'b1;
    tick(1);
    CLR = 1'b0;
    exp_push("t5_clr_rise", 0, 0, 0, 0, 0, 0);
    SENS1 = 1'b0;
    tick(12);
    exp_push("t5_no_late", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
    CLR = 1'b1;
    exp_push("t5_before_edge", 3, 0, 1, 0, 0, 0);
    tick(1);
    CLR = 1'b0;
    exp_push("t5_after_edge", 0, 0, 0, 0, 0, 0);

    // T6: EN gating, then async reset mid-debounce
    pulse(1'b1, 1'b1);
    exp_push("t6_one", 1, 1, 0, 0, 0, 0);
    EN = 1'b0;
    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b1);
    exp_push("t6_gated", 1, 1, 0, 0, 0, 0);
    EN = 1'b1;
    pulse(1'b1, 1'b1);
    exp_push("t6_reenabled", 2, 2, 0, 0, 0, 0);
    pulse(1'b1, 1'b0);
    exp_push("t6_pre_rst", 3, 2, 1, 0, 0, 0);
    SENS1 = 1'b1; SENS2 = 1'b1;
    tick(4);
    RST = 1'b0;
    SENS1 = 1'b0; SENS2 = 1'b0;
    tick(2);
    exp_push("t6_in_rst", 0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    tick(15);
    exp_push("t6_after_rst", 0, 0, 0, 0, 0, 0);

    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
